prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Writer side of the instruction-memory port: receives a framed byte stream and writes
//  16-bit instruction words into the program memory the processor fetches from (addr/clk/data).
//  Holds the processor in reset while a program is loaded, then releases it so fetch restarts at PC=0.
//  Sits between a byte source (UART RX or test bench) and the memory write port.
// PARAMETERS
//  ADDR_W     12    width of memory word address
//  DEPTH      4096  number of 16-bit words in program memory
//  BASE_ADDR  0     first address written by a load
// PORTS
//  CLOCK_50      in   1       system clock, all logic on rising edge
//  reset         in   1       synchronous, active-high
//  load_start    in   1       1-cycle pulse: begin a load (sampled only in IDLE)
//  in_valid      in   1       byte source has data
//  in_data       in   8       byte from source
//  in_ready      out  1       loader accepts byte this cycle (transfer = in_valid & in_ready)
//  mem_we        out  1       memory write strobe, 1 cycle per word
//  mem_addr      out  ADDR_W  write address
//  mem_data      out  16      write data {hi,lo}
//  cpu_hold      out  1       processor reset request, high while loading
//  busy          out  1       state != IDLE
//  done          out  1       1-cycle pulse on successful completion
//  err           out  1       sticky error flag, cleared by reset or next accepted load_start
//  words_loaded  out  ADDR_W+1 count of words written in current/last load
// BEHAVIOUR
//  Reset: all outputs 0 (in_ready, mem_we, cpu_hold, busy, done, err, words_loaded, mem_addr=BASE_ADDR,
//   mem_data=0); FSM -> IDLE. Reset mid-load aborts immediately; partially written words stay in memory.
//  Frame: LEN_HI, LEN_LO (word count N, big-endian), then N x {HI byte, LO byte}.
//  FSM: IDLE -load_start-> LEN_HI -> LEN_LO -> DAT_HI -> DAT_LO -> WRITE -> DAT_HI | FIN
//   FIN -> DONE -> IDLE.  Any -> ERR on length error; ERR -> IDLE next cycle (err stays 1).
//  in_ready = 1 only in LEN_HI, LEN_LO, DAT_HI, DAT_LO; each state advances only on a transfer,
//   otherwise holds indefinitely (no timeout).
//  load_start in IDLE: err<=0, words_loaded<=0, cpu_hold<=1 next cycle. Ignored while busy.
//  WRITE: mem_we=1 for exactly one cycle, mem_addr=BASE_ADDR+words_loaded, mem_data={hi,lo};
//   words_loaded increments same edge. Write lands 1 cycle after the LO byte transfer.
//   Max throughput 1 word / 3 cycles.
//  Length check after LEN_LO: N > DEPTH-BASE_ADDR -> ERR, no writes. N=0 -> FIN directly, no writes.
//  Last word: WRITE goes to FIN when words_loaded+1 == N. Address never wraps (guaranteed by check).
//  cpu_hold: 1 from cycle after load_start through DONE/ERR inclusive; drops to 0 on return to IDLE,
//   the cycle after done pulses. On ERR, cpu_hold also drops (processor runs partial image; err flags it).
//  done: 1 for the single DONE cycle only; never asserted together with err.
//  load_start coincident with reset: reset wins.
// CONFIGURATION
//  PROG_LOADER_CHECKSUM_EN defined: FIN state accepts one extra byte (in_ready=1) = XOR of all
//   preceding frame bytes including length bytes; match -> DONE, mismatch -> ERR (words already written).
//  Not defined: FIN is a single pass-through cycle, no checksum byte, no checksum logic synthesized.
// TESTING
//  1 Reset with in_valid=1 -> in_ready=0, mem_we=0, cpu_hold=0, mem_addr=0 for all reset cycles.
//  2 Start, stream 00 02 12 34 AB CD (continuous valid) -> mem_we at addr 0 data 1234, addr 1 data ABCD,
//    done 1 pulse, words_loaded=2, cpu_hold low the cycle after done.
//  3 Same frame with in_valid toggled 1/0 each cycle -> identical writes, no extra mem_we, no byte lost.
//  4 Start, length 10 01 (4097) -> err=1, zero mem_we, done never high; next start clears err.
//  5 Start, length 00 00 -> done after 2 byte transfers, no mem_we, words_loaded=0.
//  6 (CHECKSUM_EN) 00 01 55 AA + FE -> done; same with FF -> err=1, word 55AA still written at addr 0.

Source files
------------

// File: rtl/prog_loader.sv
// Framed byte-stream loader that writes 16-bit words into program memory while holding the CPU in reset.
// Optional trailing XOR checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, FIN, DONE, ERR
    } state_t;

    localparam int unsigned MAX_WORDS = DEPTH - BASE_ADDR;

    state_t      state, state_next;
    logic        xfer;
    logic [15:0] len_word;
    logic [15:0] len_in;
    logic [7:0]  hi_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign xfer     = in_valid & in_ready;
    assign len_in   = {len_word[15:8], in_data};
    assign busy     = (state != IDLE);
    assign cpu_hold = busy;
    assign done     = (state == DONE);
    assign mem_addr = ADDR_W'(BASE_ADDR) + words_loaded[ADDR_W-1:0];

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: if (load_start) state_next = LEN_HI;
            LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_next = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (32'(len_in) > MAX_WORDS) state_next = ERR;
                    else if (len_in == 16'd0)    state_next = FIN;
                    else                         state_next = DAT_HI;
                end
            end
            DAT_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_next = DAT_LO;
            end
            DAT_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_next = WRITE;
            end
            WRITE: begin
                mem_we = 1'b1;
                if (32'(words_loaded) + 32'd1 == 32'(len_word)) state_next = FIN;
                else                                           state_next = DAT_HI;
            end
            FIN: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                in_ready = 1'b1;
                if (in_valid) state_next = (in_data == csum) ? DONE : ERR;
`else
                state_next = DONE;
`endif
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            len_word     <= '0;
            hi_byte      <= '0;
            mem_data     <= '0;
            words_loaded <= '0;
            err          <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (load_start) begin
                    err          <= 1'b0;
                    words_loaded <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum         <= '0;
`endif
                end
                LEN_HI: if (xfer) len_word[15:8] <= in_data;
                LEN_LO: if (xfer) len_word[7:0]  <= in_data;
                DAT_HI: if (xfer) hi_byte        <= in_data;
                DAT_LO: if (xfer) mem_data       <= {hi_byte, in_data};
                WRITE:  words_loaded <= words_loaded + 1'b1;
                default: ;
            endcase
            if (state_next == ERR) err <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            // checksum covers every frame byte except the checksum byte itself
            if (xfer && state != FIN) csum <= csum ^ in_data;
`endif
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus randomized frames checked against a frame-level model.
module tb_prog_loader;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned BASE   = 0;

    logic              CLOCK_50 = 1'b0;
    logic              reset = 1'b1;
    logic              load_start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready, mem_we, cpu_hold, busy, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic [ADDR_W:0]   words_loaded;

    always #10 CLOCK_50 = ~CLOCK_50;

    prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .load_start(load_start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    int passed = 0;
    int total  = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [15:0]       wr_data_q[$];
    int                done_cnt = 0, overlap_bad = 0, hold_bad = 0;
    logic              done_d = 1'b0;
    bit [7:0]          frame_q[$];

    always @(negedge CLOCK_50) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_data);
        end
        if (done === 1'b1) done_cnt++;
        if (done === 1'b1 && err === 1'b1) overlap_bad++;
        if (done_d === 1'b1 && cpu_hold !== 1'b0) hold_bad++;
        done_d = done;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic append_csum(input bit corrupt);
        bit [7:0] x = 8'h00;
        foreach (frame_q[i]) x ^= frame_q[i];
        frame_q.push_back(corrupt ? ~x : x);
    endtask

    task automatic build_frame(input int n, input bit corrupt);
        frame_q.delete();
        frame_q.push_back(8'(n >> 8));
        frame_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            frame_q.push_back(8'($urandom));
            frame_q.push_back(8'($urandom));
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        append_csum(corrupt);
`else
        if (corrupt) ;
`endif
    endtask

    task automatic start_load();
        @(negedge CLOCK_50);
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0; overlap_bad = 0; hold_bad = 0;
        load_start = 1'b1;
        @(negedge CLOCK_50);
        load_start = 1'b0;
        check("start_hold", cpu_hold, 1);
        check("start_busy", busy, 1);
        check("start_err_clr", err, 0);
        check("start_wl_clr", words_loaded, 0);
    endtask

    // mode 0: continuous valid, 1: valid toggles each cycle, 2: random valid with stray load_start pulses
    task automatic send_frame(input int mode);
        int idx = 0;
        int cyc = 0;
        bit v;
        while (idx < frame_q.size() && cyc < 30000) begin
            @(negedge CLOCK_50);
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom);
            endcase
            load_start = (mode == 2) && ($urandom_range(0, 4) == 0);
            in_valid = v;
            in_data  = frame_q[idx];
            if (v && in_ready === 1'b1) idx++;
            cyc++;
        end
        @(negedge CLOCK_50);
        in_valid = 1'b0; load_start = 1'b0; in_data = 8'h00;
        check("frame_consumed", idx, frame_q.size());
    endtask

    task automatic finish_load();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("idle_reached", busy, 0);
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic check_result(input string tag);
        int n;
        bit len_err, cs_ok, exp_err;
        int exp_nw, bad;
        n = {frame_q[0], frame_q[1]};
        len_err = n > int'(DEPTH - BASE);
        cs_ok = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
        if (!len_err) begin
            bit [7:0] x = 8'h00;
            for (int i = 0; i < 2 + 2 * n; i++) x ^= frame_q[i];
            cs_ok = (x == frame_q[2 + 2 * n]);
        end
`endif
        exp_err = len_err || !cs_ok;
        exp_nw  = len_err ? 0 : n;
        check({tag, "_err"}, err, exp_err);
        check({tag, "_done_cnt"}, done_cnt, exp_err ? 0 : 1);
        check({tag, "_words"}, words_loaded, exp_nw);
        check({tag, "_nwrites"}, wr_data_q.size(), exp_nw);
        bad = 0;
        for (int i = 0; i < wr_data_q.size() && i < exp_nw; i++)
            if (wr_addr_q[i] !== ADDR_W'(BASE + i) ||
                wr_data_q[i] !== {frame_q[2 + 2 * i], frame_q[3 + 2 * i]}) bad++;
        check({tag, "_write_mismatches"}, bad, 0);
        check({tag, "_done_err_overlap"}, overlap_bad, 0);
        check({tag, "_hold_after_done"}, hold_bad, 0);
        check({tag, "_hold_idle"}, cpu_hold, 0);
    endtask

    initial begin
        // reset with valid data and a coincident load_start
        in_valid = 1'b1; in_data = 8'hA5; load_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK_50);
            check("rst_in_ready", in_ready, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_cpu_hold", cpu_hold, 0);
            check("rst_mem_addr", mem_addr, BASE);
        end
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_words", words_loaded, 0);
        check("rst_mem_data", mem_data, 0);
        reset = 1'b0; in_valid = 1'b0; load_start = 1'b0;
        @(negedge CLOCK_50);
        check("post_rst_idle", busy, 0);

        // two-word frame, continuous then toggled valid
        for (int m = 0; m < 2; m++) begin
            frame_q.delete();
            frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef PROG_LOADER_CHECKSUM_EN
            append_csum(1'b0);
`endif
            start_load();
            send_frame(m);
            finish_load();
            check_result(m == 0 ? "two_cont" : "two_toggle");
            check("two_w0", wr_data_q.size() > 0 ? wr_data_q[0] : 16'hxxxx, 16'h1234);
            check("two_w1", wr_data_q.size() > 1 ? wr_data_q[1] : 16'hxxxx, 16'hABCD);
        end

        // length one past capacity
        frame_q.delete();
        frame_q = '{8'h10, 8'h01};
        start_load();
        send_frame(0);
        finish_load();
        check_result("len_over");

        // zero length
        frame_q.delete();
        frame_q = '{8'h00, 8'h00};
`ifdef PROG_LOADER_CHECKSUM_EN
        append_csum(1'b0);
`endif
        start_load();
        send_frame(0);
        finish_load();
        check_result("len_zero");

`ifdef PROG_LOADER_CHECKSUM_EN
        for (int k = 0; k < 2; k++) begin
            frame_q.delete();
            frame_q = '{8'h00, 8'h01, 8'h55, 8'hAA};
            frame_q.push_back(k == 0 ? 8'hFE : 8'hFF);
            start_load();
            send_frame(0);
            finish_load();
            check_result(k == 0 ? "cs_good" : "cs_bad");
            check("cs_w0", wr_data_q.size() > 0 ? wr_data_q[0] : 16'hxxxx, 16'h55AA);
        end
`endif

        // randomized frames
        for (int r = 0; r < 8; r++) begin
            build_frame($urandom_range(1, 6), $urandom_range(0, 3) == 0);
            start_load();
            send_frame($urandom_range(0, 2));
            finish_load();
            check_result("rand");
        end

        // full capacity
        build_frame(int'(DEPTH - BASE), 1'b0);
        start_load();
        send_frame(0);
        finish_load();
        check_result("full");
        check("full_last_addr", wr_addr_q.size() > 0 ? 32'(wr_addr_q[$]) : 32'hxxxxxxxx, DEPTH - 1);

        // reset mid-load aborts immediately
        start_load();
        in_valid = 1'b1; in_data = 8'h00;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        check("midrst_busy", busy, 0);
        check("midrst_hold", cpu_hold, 0);
        check("midrst_ready", in_ready, 0);
        reset = 1'b0; in_valid = 1'b0;
        @(negedge CLOCK_50);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
